// File: rtl/gfb_pkg.sv
// Shared mode encoding and per-lane reset defaults for the gate-feedback bank.
package gfb_pkg;

    localparam int GFB_MODE_W = 2;

    typedef enum logic [GFB_MODE_W-1:0] {
        GFB_XOR  = 2'b00,
        GFB_ANDN = 2'b01,
        GFB_ORN  = 2'b10,
        GFB_HOLD = 2'b11
    } gfb_mode_e;

    // Lanes cycle XOR, ANDN, ORN so the three-lane build matches the legacy circuit.
    function automatic gfb_mode_e gfb_default_mode(input int unsigned idx);
        case (idx % 3)
            0:       return GFB_XOR;
            1:       return GFB_ANDN;
            default: return GFB_ORN;
        endcase
    endfunction

endpackage

// File: rtl/gfb_lane.sv
// One feedback lane: WIDTH-bit state register, its mode register and the
// next-state mux selected by that mode.
module gfb_lane
    import gfb_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int LANE_IDX = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] x,
    input  logic             mode_we,
    input  gfb_mode_e        mode_wd,
    output logic [WIDTH-1:0] q
);

    localparam gfb_mode_e RST_MODE = gfb_default_mode(LANE_IDX);

    logic [WIDTH-1:0] state_q, state_d;
    gfb_mode_e        mode_q, mode_d;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        if (clr) begin
            state_d = '0;
        end else if (en) begin
            unique case (mode_q)
                GFB_XOR:  state_d = x ^ state_q;
                GFB_ANDN: state_d = x & ~state_q;
                GFB_ORN:  state_d = x | ~state_q;
                GFB_HOLD: state_d = state_q;
            endcase
        end
        if (mode_we) begin
            mode_d = mode_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            mode_q  <= RST_MODE;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    assign q = state_q;

endmodule

// File: rtl/gfb_bank.sv
// Gate-feedback state bank: NUM_LANES lanes folded into an XNOR-reduced output.
// Define GFB_OUT_REG_EN to register z (one cycle state->z latency).
module gfb_bank
    import gfb_pkg::*;
#(
    parameter int NUM_LANES = 3,
    parameter int WIDTH     = 1,
    parameter int CNT_W     = 16,
    localparam int LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [WIDTH-1:0]  x,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [LANE_W-1:0] cfg_lane,
    input  logic [1:0]        cfg_mode,
    output logic [WIDTH-1:0]  z,
    output logic [CNT_W-1:0]  step_cnt
);

    logic [WIDTH-1:0] lane_q [NUM_LANES];
    logic             cfg_we;
    logic [WIDTH-1:0] fold;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cfg_ready = ~en;
    assign cfg_we    = cfg_valid & cfg_ready;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        gfb_lane #(
            .WIDTH    (WIDTH),
            .LANE_IDX (i)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .clr     (clr),
            .x       (x),
            .mode_we (cfg_we && (int'(cfg_lane) == i)),
            .mode_wd (gfb_mode_e'(cfg_mode)),
            .q       (lane_q[i])
        );
    end

    always_comb begin
        fold = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            fold = fold ^ lane_q[i];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step_cnt = cnt_q;

`ifdef GFB_OUT_REG_EN
    logic [WIDTH-1:0] z_q, z_d;

    always_comb begin
        z_d = clr ? '1 : ~fold;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= '1;
        end else begin
            z_q <= z_d;
        end
    end

    assign z = z_q;
`else
    assign z = ~fold;
`endif

endmodule
